// File: rtl/ask4_carrier_mux_pkg.sv
// Shared types for the 4-ASK carrier mux: symbol encoding and switch FSM states.
package ask4_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_C1 = 2'b00;
    localparam sym_t SYM_C2 = 2'b01;
    localparam sym_t SYM_C3 = 2'b10;
    localparam sym_t SYM_C4 = 2'b11;

    localparam int unsigned NUM_CARRIERS = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/ask4_carrier_mux_if.sv
// Carrier/symbol bundle between the carrier generators and the mux output stage.
interface ask4_carrier_mux_if;
    import ask4_pkg::*;

    logic carrier1;
    logic carrier2;
    logic carrier3;
    logic carrier4;
    sym_t sel;
    logic out;
    sym_t sel_cur;
    logic pending;

    modport master (
        output carrier1, carrier2, carrier3, carrier4, sel,
        input  out, sel_cur, pending
    );

    modport slave (
        input  carrier1, carrier2, carrier3, carrier4, sel,
        output out, sel_cur, pending
    );

endinterface

// File: rtl/ask4_carrier_mux_sync_nff.sv
// N-stage reset-to-zero synchroniser for asynchronous level inputs.
module sync_nff #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/ask4_carrier_mux.sv
// 4-ASK output stage: routes one synchronised carrier to a registered output and
// defers symbol changes until both old and new carriers are low (or a timeout).
module ask4_carrier_mux
    import ask4_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SWITCH_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    ask4_carrier_mux_if.slave  bus
);

    localparam int unsigned CNT_W = (SWITCH_TIMEOUT > 1) ? $clog2(SWITCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWITCH_TIMEOUT - 1);

    logic [NUM_CARRIERS-1:0] c_s;
    sym_t                    sel_s;

    state_t           state, state_nxt;
    sym_t             target, target_nxt;
    sym_t             sel_cur, sel_cur_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             out_r;
    logic             pending_r;

    logic both_low_c;
    logic timeout_c;

    sync_nff #(.STAGES(SYNC_STAGES), .WIDTH(NUM_CARRIERS)) u_sync_car (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.carrier4, bus.carrier3, bus.carrier2, bus.carrier1}),
        .q     (c_s)
    );

    sync_nff #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.sel),
        .q     (sel_s)
    );

    assign both_low_c = ~c_s[sel_cur] & ~c_s[target];
    assign timeout_c  = (cnt == CNT_LAST);

    // State and datapath registers; output samples the carrier of the committed symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            target    <= SYM_C1;
            sel_cur   <= SYM_C1;
            cnt       <= '0;
            out_r     <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            sel_cur   <= sel_cur_nxt;
            cnt       <= cnt_nxt;
            out_r     <= c_s[sel_cur];
            pending_r <= (state_nxt == PENDING);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sel_s != sel_cur) state_nxt = PENDING;
            end
            PENDING: begin
                if (sel_s == sel_cur)              state_nxt = IDLE;
                else if (sel_s != target)          state_nxt = PENDING;
                else if (both_low_c || timeout_c)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Target capture, timeout counting and commit; a retarget restarts the wait.
    always_comb begin
        target_nxt  = target;
        sel_cur_nxt = sel_cur;
        cnt_nxt     = cnt;
        case (state)
            IDLE: begin
                if (sel_s != sel_cur) begin
                    target_nxt = sel_s;
                    cnt_nxt    = '0;
                end
            end
            PENDING: begin
                if (sel_s == sel_cur) begin
                    cnt_nxt = '0;
                end else if (sel_s != target) begin
                    target_nxt = sel_s;
                    cnt_nxt    = '0;
                end else if (both_low_c || timeout_c) begin
                    sel_cur_nxt = target;
                end else begin
                    cnt_nxt = CNT_W'(cnt + CNT_W'(1));
                end
            end
            default: ;
        endcase
    end

    assign bus.out     = out_r;
    assign bus.sel_cur = sel_cur;
    assign bus.pending = pending_r;

endmodule

// File: tb/tb_ask4_carrier_mux.sv
// Directed bench for ask4_carrier_mux: reset, pass-through, safe/forced switching, abort, async reset.
module tb_ask4_carrier_mux;

    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned SWITCH_TIMEOUT = 64;

    logic       clk;
    logic       rst_n;
    logic [3:0] car;
    logic [1:0] sel_d;
    logic       hist [0:39];
    logic       v;

    int checks;
    int errors;

    ask4_carrier_mux_if bus ();

    assign bus.carrier1 = car[0];
    assign bus.carrier2 = car[1];
    assign bus.carrier3 = car[2];
    assign bus.carrier4 = car[3];
    assign bus.sel      = sel_d;

    ask4_carrier_mux #(
        .SYNC_STAGES    (SYNC_STAGES),
        .SWITCH_TIMEOUT (SWITCH_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        car    = 4'b0000;
        sel_d  = 2'b00;

        // reset held with toggling carriers
        for (int i = 0; i < 6; i++) begin
            car = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            tick();
            chk("rst_out",     2'(bus.out),     2'b00);
            chk("rst_sel_cur", 2'(bus.sel_cur), 2'b00);
            chk("rst_pending", 2'(bus.pending), 2'b00);
        end
        car   = 4'b0000;
        rst_n = 1'b1;
        repeat (4) tick();

        // pass-through on each symbol, carrier periods 2/4/8/16 clk
        for (int k = 0; k < 4; k++) begin
            car   = 4'b0000;
            sel_d = 2'(k);
            repeat (8) tick();
            chk("pass_sel_cur", 2'(bus.sel_cur), 2'(k));
            chk("pass_idle",    2'(bus.pending), 2'b00);
            for (int i = 0; i < 40; i++) begin
                v       = (((i >> k) & 1) != 0);
                hist[i] = v;
                car[k]  = v;
                tick();
                if (i >= 2) chk("pass_out", 2'(bus.out), 2'(hist[i-2]));
            end
        end

        // back to symbol 0
        car   = 4'b0000;
        sel_d = 2'b00;
        repeat (8) tick();
        chk("ret0_sel_cur", 2'(bus.sel_cur), 2'b00);

        // safe switch 0->3 while carrier1 is high
        car = 4'b0001;
        repeat (4) tick();
        chk("safe_out_hi", 2'(bus.out), 2'b01);
        sel_d = 2'b11;
        repeat (3) tick();
        chk("safe_pending",  2'(bus.pending), 2'b01);
        chk("safe_hold_sel", 2'(bus.sel_cur), 2'b00);
        repeat (5) tick();
        chk("safe_wait_pend", 2'(bus.pending), 2'b01);
        chk("safe_wait_out",  2'(bus.out),     2'b01);
        car = 4'b0000;
        repeat (2) tick();
        chk("safe_pre_commit", 2'(bus.pending), 2'b01);
        chk("safe_pre_sel",    2'(bus.sel_cur), 2'b00);
        tick();
        chk("safe_commit_sel",  2'(bus.sel_cur), 2'b11);
        chk("safe_commit_pend", 2'(bus.pending), 2'b00);
        chk("safe_commit_out",  2'(bus.out),     2'b00);
        tick();
        chk("safe_after_out", 2'(bus.out), 2'b00);
        car = 4'b1000;
        repeat (3) tick();
        chk("safe_new_carrier", 2'(bus.out), 2'b01);

        // back to symbol 0, then forced commit with carrier4 DC-high
        car   = 4'b0000;
        sel_d = 2'b00;
        repeat (8) tick();
        chk("ret0b_sel_cur", 2'(bus.sel_cur), 2'b00);
        car = 4'b1000;
        repeat (3) tick();
        sel_d = 2'b11;
        repeat (3) tick();
        chk("to_enter_pend", 2'(bus.pending), 2'b01);
        repeat (SWITCH_TIMEOUT - 1) tick();
        chk("to_last_pend", 2'(bus.pending), 2'b01);
        chk("to_last_sel",  2'(bus.sel_cur), 2'b00);
        tick();
        chk("to_commit_sel",  2'(bus.sel_cur), 2'b11);
        chk("to_commit_pend", 2'(bus.pending), 2'b00);
        chk("to_commit_out",  2'(bus.out),     2'b00);
        tick();
        chk("to_new_out", 2'(bus.out), 2'b01);

        // back to symbol 0, then abort 0->2->0
        car   = 4'b0000;
        sel_d = 2'b00;
        repeat (8) tick();
        chk("ret0c_sel_cur", 2'(bus.sel_cur), 2'b00);
        car = 4'b0101;
        repeat (4) tick();
        sel_d = 2'b10;
        repeat (3) tick();
        chk("abort_pend", 2'(bus.pending), 2'b01);
        sel_d = 2'b00;
        repeat (2) tick();
        chk("abort_still_pend", 2'(bus.pending), 2'b01);
        tick();
        chk("abort_dropped", 2'(bus.pending), 2'b00);
        chk("abort_sel_cur", 2'(bus.sel_cur), 2'b00);
        repeat (3) tick();
        chk("abort_stable", 2'(bus.sel_cur), 2'b00);

        // retarget 0->1->2 restarts the timeout
        car   = 4'b0111;
        sel_d = 2'b01;
        repeat (3) tick();
        chk("rt_pend", 2'(bus.pending), 2'b01);
        repeat (10) tick();
        sel_d = 2'b10;
        repeat (3) tick();
        repeat (SWITCH_TIMEOUT - 1) tick();
        chk("rt_last_pend", 2'(bus.pending), 2'b01);
        chk("rt_last_sel",  2'(bus.sel_cur), 2'b00);
        tick();
        chk("rt_commit_sel",  2'(bus.sel_cur), 2'b10);
        chk("rt_commit_pend", 2'(bus.pending), 2'b00);

        // async reset while pending
        sel_d = 2'b00;
        repeat (3) tick();
        chk("ar_pend", 2'(bus.pending), 2'b01);
        chk("ar_out",  2'(bus.out),     2'b01);
        #4 rst_n = 1'b0;
        #1;
        chk("ar_sel_cur", 2'(bus.sel_cur), 2'b00);
        chk("ar_pending", 2'(bus.pending), 2'b00);
        chk("ar_out_rst", 2'(bus.out),     2'b00);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("ar_post_pend", 2'(bus.pending), 2'b00);
        chk("ar_post_sel",  2'(bus.sel_cur), 2'b00);
        chk("ar_post_out",  2'(bus.out),     2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
